// File: rtl/time_pkg.sv
// Shared timing types for the pulse generator and TimeMeasurement.
package time_pkg;

  localparam int TIME_W = 6;

  typedef enum logic [0:0] {IDLE, RUN} tpg_state_t;

  typedef logic [TIME_W-1:0] time_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle time-unit ticks while run is high; clr restarts the count.
module tick_prescaler #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick = run && (pre_q == PRE_LAST);

  // clr beats run so a reload or a fresh start always begins a full unit
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (run) begin
      if (tick) pre_d = '0;
      else      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/time_pulse_generator.sv
// Drives en high for exactly dur time units (dur*TICK_DIV clk cycles).
// Optional macro TIME_PULSE_RETRIGGER_EN lets start in RUN reload the window.
module time_pulse_generator
  import time_pkg::*;
#(
  parameter int TIME_W   = time_pkg::TIME_W,
  parameter int TICK_DIV = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TIME_W-1:0] dur,
  input  logic              abort,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic [TIME_W-1:0] remaining
);

  tpg_state_t        state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              clr, run, tick;

  assign run = (state_q == RUN);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    en_d    = en_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr = 1'b1;
          if (dur != '0) begin
            state_d = RUN;
            rem_d   = dur;
            en_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          rem_d   = '0;
          en_d    = 1'b0;
          clr     = 1'b1;
`ifdef TIME_PULSE_RETRIGGER_EN
        end else if (start) begin
          // Reload keeps en high; a zero reload ends the window as a completion
          clr = 1'b1;
          if (dur != '0) begin
            rem_d = dur;
          end else begin
            state_d = IDLE;
            rem_d   = '0;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end
`endif
        end else if (tick) begin
          if (rem_q <= 1) begin
            state_d = IDLE;
            rem_d   = '0;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign en        = en_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_time_pulse_generator.sv
// Directed bench for time_pulse_generator (TICK_DIV=4, plus a TICK_DIV=1 instance).
module tb_time_pulse_generator;

  localparam int TIME_W   = 6;
  localparam int TICK_DIV = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [TIME_W-1:0] dur;
  logic              abort;
  logic              en, busy, done;
  logic [TIME_W-1:0] remaining;

  logic              start1;
  logic [TIME_W-1:0] dur1;
  logic              en1, busy1, done1;
  logic [TIME_W-1:0] remaining1;

  int testsRun   = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  time_pulse_generator #(.TIME_W(TIME_W), .TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dur       (dur),
    .abort     (abort),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  time_pulse_generator #(.TIME_W(TIME_W), .TICK_DIV(1)) dutDiv1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .dur       (dur1),
    .abort     (1'b0),
    .en        (en1),
    .busy      (busy1),
    .done      (done1),
    .remaining (remaining1)
  );

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input int d, input logic a);
    start = s;
    dur   = TIME_W'(d);
    abort = a;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Runs until en falls (or budget expires), counting en-high cycles and done pulses
  task automatic measureWindow(input int budget, output int enCycles,
                               output int donePulses, output bit timedOut);
    enCycles   = 0;
    donePulses = 0;
    timedOut   = 1'b1;
    for (int i = 0; i < budget; i++) begin
      stepClock();
      if (en)   enCycles++;
      if (done) donePulses++;
      if (!en) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int  enCycles, donePulses, measRes;
    bit  timedOut;

    applyStimulus(1'b0, 0, 1'b0);
    start1 = 1'b0;
    dur1   = '0;

    // 1: reset held three cycles
    rst = 1'b1;
    repeat (3) stepClock();
    checkOutput("rst_en", en, 0);
    rst = 1'b0;
    stepClock();
    checkOutput("post_rst_en", en, 0);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_done", done, 0);
    checkOutput("post_rst_rem", remaining, 0);

    // 2: dur=5, 20-cycle window with stepping remaining
    applyStimulus(1'b1, 5, 1'b0);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("d5_busy", busy, 1);
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("d5_en_k%0d", k), en, 1);
      checkOutput($sformatf("d5_rem_k%0d", k), remaining, 5 - k / 4);
      checkOutput($sformatf("d5_done_k%0d", k), done, 0);
      stepClock();
    end
    checkOutput("d5_end_en", en, 0);
    checkOutput("d5_end_done", done, 1);
    checkOutput("d5_end_busy", busy, 0);
    checkOutput("d5_end_rem", remaining, 0);
    stepClock();
    checkOutput("d5_done_cleared", done, 0);

    // 3: dur=0 gives a done pulse with no window
    applyStimulus(1'b1, 0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("d0_done", done, 1);
    checkOutput("d0_en", en, 0);
    checkOutput("d0_busy", busy, 0);
    stepClock();
    checkOutput("d0_done_cleared", done, 0);
    checkOutput("d0_en_after", en, 0);

    // 4: dur=10 aborted after 9 cycles
    applyStimulus(1'b1, 10, 1'b0);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    repeat (9) stepClock();
    checkOutput("abort_pre_rem", remaining, 8);
    checkOutput("abort_pre_en", en, 1);
    applyStimulus(1'b0, 0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("abort_en", en, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rem", remaining, 0);
    checkOutput("abort_done", done, 0);
    stepClock();
    checkOutput("abort_done_after", done, 0);

    // 5: start during RUN (ignored, or reload with the retrigger build)
    applyStimulus(1'b1, 3, 1'b0);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    repeat (5) stepClock();
    checkOutput("retrig_pre_en", en, 1);
    applyStimulus(1'b1, 2, 1'b0);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("retrig_en_kept", en, 1);
    measureWindow(40, enCycles, donePulses, timedOut);
    checkOutput("retrig_timeout", timedOut, 0);
`ifdef TIME_PULSE_RETRIGGER_EN
    checkOutput("retrig_en_total", 6 + 1 + enCycles, 14);
`else
    checkOutput("retrig_en_total", 6 + 1 + enCycles, 12);
`endif
    checkOutput("retrig_done_pulses", donePulses, 1);

    // abort beats a simultaneous start in RUN
    applyStimulus(1'b1, 5, 1'b0);
    stepClock();
    applyStimulus(1'b1, 7, 1'b1);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("abort_start_en", en, 0);
    checkOutput("abort_start_busy", busy, 0);
    checkOutput("abort_start_done", done, 0);

    // start with abort in IDLE: abort ignored
    applyStimulus(1'b1, 2, 1'b1);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("idle_abort_en", en, 1);
    checkOutput("idle_abort_rem", remaining, 2);
    measureWindow(20, enCycles, donePulses, timedOut);
    checkOutput("idle_abort_len", 1 + enCycles, 8);
    checkOutput("idle_abort_timeout", timedOut, 0);

    // 6: loopback into a TimeMeasurement model, dur=63
    applyStimulus(1'b1, 63, 1'b0);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    measureWindow(300, enCycles, donePulses, timedOut);
    measRes = (1 + enCycles) / TICK_DIV;
    checkOutput("loop_timeout", timedOut, 0);
    checkOutput("loop_res", measRes, 63);
    checkOutput("loop_cycles", 1 + enCycles, 63 * TICK_DIV);
    checkOutput("loop_done", donePulses, 1);

    // reset mid-window drops en on the next edge
    applyStimulus(1'b1, 63, 1'b0);
    stepClock();
    applyStimulus(1'b0, 0, 1'b0);
    repeat (99) stepClock();
    checkOutput("midrst_pre_en", en, 1);
    checkOutput("midrst_pre_rem", remaining, 63 - 99 / 4);
    rst = 1'b1;
    stepClock();
    checkOutput("midrst_en", en, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rem", remaining, 0);
    checkOutput("midrst_done", done, 0);
    rst = 1'b0;
    stepClock();

    // TICK_DIV=1: remaining decrements every cycle
    start1 = 1'b1;
    dur1   = 6'd3;
    stepClock();
    start1 = 1'b0;
    dur1   = '0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("div1_en_k%0d", k), en1, 1);
      checkOutput($sformatf("div1_rem_k%0d", k), remaining1, 3 - k);
      stepClock();
    end
    checkOutput("div1_end_en", en1, 0);
    checkOutput("div1_end_done", done1, 1);
    checkOutput("div1_end_busy", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
